qos_arbiter: RTL and testbench
==============================

# qos_arbiter

Four-class output scheduler sitting directly downstream of the QoS flow-control FSM and its four class FIFOs. Consumes the FSM's `pause_stb`, `continue_stb`, `idle` and `error_full` outputs, holds a per-class pause mask, and drains the class FIFOs into one output stream with quantum-based round-robin. On any FIFO overflow it halts permanently until reset.

## Interface
- `DATA_W`, 10: payload width of each class FIFO and of the output.
- `QUANTUM`, 4: maximum consecutive pops granted to one class before the grant rotates (1..15).
- `CLK`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `pause_stb`  input  4  one-cycle pause strobes from the FSM, bit i = class i.
- `continue_stb`  input  4  one-cycle continue strobes from the FSM.
- `idle`  input  1  FSM idle indication (all FIFOs empty after init).
- `error_full`  input  4  FSM overflow report; any bit set triggers halt.
- `empty`  input  4  class FIFO empty flags.
- `data_in0`..`data_in3`  input  DATA_W each  class FIFO read data, valid the cycle after `pop`.
- `out_full`  input  1  downstream almost-full; asserted with at least 2 entries of margin.
- `pop`  output  4  one-hot (or zero) FIFO read enable.
- `data_out`  output  DATA_W  registered payload.
- `valid_out`  output  1  registered qualifier for `data_out`.
- `paused`  output  4  current pause mask.
- `halted`  output  1  high in HALT state.

## Operation
- Reset: state WAIT, `pop`=0, `data_out`=0, `valid_out`=0, `paused`=0, `halted`=0, pointer=0, burst count=0.
- Pause mask: per bit, `pause_stb` sets, `continue_stb` clears; both set in the same cycle → pause wins. Mask updates in WAIT and RUN; frozen in HALT.
- States:
  - WAIT: no pops. `idle`=1 → RUN. `error_full`≠0 → HALT (priority).
  - RUN: arbitrate each cycle. `error_full`≠0 → HALT. Never leaves otherwise.
  - HALT: `pop`=0, `halted`=1, in-flight read still completes onto `data_out`. Exit only via reset.
- Eligibility: class i eligible when `empty[i]`=0, `paused[i]`=0, `out_full`=0. `out_full`=1 → no pop that cycle.
- Grant: if the current class (pointer) is eligible and burst count < QUANTUM, pop it and increment count. Otherwise search from pointer+1 upward, mod 4, for the first eligible class; pop it, move the pointer there, count=1. No eligible class → no pop; pointer and count hold.
- Pause/continue strobes take effect on eligibility in the cycle after the strobe. A strobe arriving in the same cycle as a pop does not cancel that pop.
- Count is 4 bits and saturates at QUANTUM. Pointer is 2 bits and wraps 3→0.

## Timing
- `pop` is registered: the decision is made from inputs in cycle N, and `pop` is high during cycle N+1.
- FIFO data is valid in cycle N+2. `data_out` and `valid_out` are registered from the selected `data_inX` at the end of N+2 and visible in N+3.
- Pop-to-output latency: 2 cycles.
- Sustained throughput: 1 word/cycle.
- `valid_out` is high exactly one cycle per pop. It is 0 otherwise, and `data_out` holds its last value.
- An asynchronous reset in mid-burst discards the in-flight word; `valid_out` drops immediately.

## Structure
- Shared package `qos_pkg`:
  - State encoding: WAIT, RUN, HALT.
  - `NUM_CLASSES`=4.
  - Class index type (2 bits).
- Sub-module `rr_pick`: a combinational 4-bit rotate-priority search. Inputs are the eligibility vector and the start index. Outputs are the found flag and the one-hot/index result.
- Everything else (mask, FSM, counter, data register) lives in `qos_arbiter`.

## Test plan
- Reset then `idle`=1, class 2 non-empty only, holding 3 words A,B,C:
  - `pop`=0100 for 3 cycles.
  - `valid_out` shows A,B,C starting 2 cycles after the first pop.
- All four classes non-empty, QUANTUM=4, no pauses: grant sequence 0×4, 1×4, 2×4, 3×4, 0×4…
- `pause_stb`=0001 during a class-0 burst:
  - Class 0 pops end 1 cycle later and the grant moves to class 1.
  - `continue_stb`=0001 re-enables it; class 0 is served after class 3.
- `pause_stb`=`continue_stb`=1000 in the same cycle: `paused[3]`=1.
- `out_full`=1 for 5 cycles with all classes non-empty:
  - Zero pops during the stall.
  - Pointer and count resume unchanged afterwards.
- `error_full`=0010 during RUN, with one word in flight:
  - `halted`=1 next cycle and `pop`=0.
  - The in-flight word still appears once on `valid_out`.
  - Only reset returns the block to WAIT.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared types for the four-class QoS output scheduler.
package qos_pkg;
    localparam int NUM_CLASSES = 4;

    typedef logic [1:0] cls_t;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority search over four requests, starting at 'start'.
// Zero latency; pure function of its inputs.
module rr_pick
    import qos_pkg::*;
(
    input  logic [NUM_CLASSES-1:0] req,
    input  cls_t                   start,
    output logic                   found,
    output logic [NUM_CLASSES-1:0] grant_oh,
    output cls_t                   grant_idx
);
    cls_t idx;

    // Walk from the farthest offset down so the closest hit to 'start' wins last.
    always_comb begin
        found     = 1'b0;
        grant_idx = start;
        idx       = start;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            idx = start + cls_t'(i);
            if (req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant_oh = found ? (4'b0001 << grant_idx) : 4'b0000;
    end
endmodule

// File: rtl/qos_arbiter.sv
// Quantum round-robin drain of four class FIFOs into one stream; pop registered, data out 2 cycles after pop.
// out_full or a paused/empty class suppresses pops; any FIFO overflow report halts until reset.
module qos_arbiter
    import qos_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int QUANTUM = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [3:0]        pause_stb,
    input  logic [3:0]        continue_stb,
    input  logic              idle,
    input  logic [3:0]        error_full,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              out_full,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [3:0]        paused,
    output logic              halted
);
    localparam logic [3:0] QUANT = 4'(QUANTUM);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        mask_nxt;
    logic [3:0]        pop_nxt;
    logic [3:0]        elig;
    logic [3:0]        pick_oh;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    cls_t              ptr;
    cls_t              ptr_nxt;
    cls_t              pick_idx;
    cls_t              rd_idx;
    logic              pick_found;
    logic              stay;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_dat;

    assign elig   = ~empty & ~paused & {4{~out_full}};
    assign stay   = elig[ptr] && (cnt < QUANT);
    assign halted = (state == ST_HALT);

    // The current class is retried last, so a lone eligible class keeps streaming.
    rr_pick u_pick (
        .req       (elig),
        .start     (cls_t'(ptr + 2'd1)),
        .found     (pick_found),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        pop_nxt   = 4'b0000;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        mask_nxt  = (paused & ~continue_stb) | pause_stb;
        case (state)
            ST_WAIT: begin
                if (|error_full) state_nxt = ST_HALT;
                else if (idle)   state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (|error_full) begin
                    state_nxt = ST_HALT;
                end else if (stay) begin
                    pop_nxt[ptr] = 1'b1;
                    cnt_nxt      = cnt + 4'd1;
                end else if (pick_found) begin
                    pop_nxt = pick_oh;
                    ptr_nxt = pick_idx;
                    cnt_nxt = 4'd1;
                end
            end
            default: begin
                state_nxt = ST_HALT;
                mask_nxt  = paused;
            end
        endcase
    end

    always_comb begin
        case (rd_idx)
            2'd0:    rd_dat = data_in0;
            2'd1:    rd_dat = data_in1;
            2'd2:    rd_dat = data_in2;
            default: rd_dat = data_in3;
        endcase
    end

    // ptr always names the class being popped, so it doubles as the read-data select.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= ST_WAIT;
            paused    <= 4'b0000;
            pop       <= 4'b0000;
            ptr       <= '0;
            cnt       <= 4'd0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            paused    <= mask_nxt;
            pop       <= pop_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            rd_vld    <= |pop;
            rd_idx    <= ptr;
            valid_out <= rd_vld;
            if (rd_vld) data_out <= rd_dat;
        end
    end
endmodule

// File: tb/tb_qos_arbiter.sv
// Randomized and directed bench for qos_arbiter against a cycle-level reference model and data scoreboard.
module tb_qos_arbiter;
    localparam int DW = 10;
    localparam int Q  = 4;
    localparam int M_WAIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          CLK;
    logic          reset;
    logic [3:0]    pause_stb;
    logic [3:0]    continue_stb;
    logic          idle;
    logic [3:0]    error_full;
    logic [3:0]    empty_r;
    logic [DW-1:0] din [4];
    logic          out_full;
    logic [3:0]    pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [3:0]    paused;
    logic          halted;

    qos_arbiter #(.DATA_W(DW), .QUANTUM(Q)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .pause_stb    (pause_stb),
        .continue_stb (continue_stb),
        .idle         (idle),
        .error_full   (error_full),
        .empty        (empty_r),
        .data_in0     (din[0]),
        .data_in1     (din[1]),
        .data_in2     (din[2]),
        .data_in3     (din[3]),
        .out_full     (out_full),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .paused       (paused),
        .halted       (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef logic [DW-1:0] wq_t [$];
    wq_t fq [4];
    logic [DW-1:0] sb [$];

    int n_chk;
    int n_fail;

    int            m_st, m_ptr, m_cnt, m_rd;
    logic [3:0]    m_mask, m_pop, m_pop_prev;
    logic [DW-1:0] m_dout;
    logic          m_vld;
    int            n_st, n_ptr, n_cnt, n_rd;
    logic [3:0]    n_mask, n_pop;
    logic [DW-1:0] n_dout;
    logic          n_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_WAIT; m_ptr = 0; m_cnt = 0; m_rd = -1;
        m_mask = 4'b0; m_pop = 4'b0; m_pop_prev = 4'b0;
        m_dout = '0; m_vld = 1'b0;
    endtask

    task automatic model_next();
        logic [3:0] el;
        bit hit;
        n_mask = (m_st == M_HALT) ? m_mask : ((m_mask & ~continue_stb) | pause_stb);
        n_st = m_st;
        if (m_st == M_WAIT && error_full != 0)      n_st = M_HALT;
        else if (m_st == M_WAIT && idle)            n_st = M_RUN;
        else if (m_st == M_RUN && error_full != 0)  n_st = M_HALT;
        n_pop = 4'b0; n_ptr = m_ptr; n_cnt = m_cnt;
        if (m_st == M_RUN && error_full == 0 && !out_full) begin
            el = ~empty_r & ~m_mask;
            if (el[m_ptr] && m_cnt < Q) begin
                n_pop[m_ptr] = 1'b1;
                n_cnt = m_cnt + 1;
            end else begin
                hit = 0;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_ptr + k) % 4;
                    if (!hit && el[c]) begin
                        hit = 1; n_pop[c] = 1'b1; n_ptr = c; n_cnt = 1;
                    end
                end
            end
        end
        n_rd = -1;
        for (int i = 0; i < 4; i++) if (m_pop[i]) n_rd = i;
        n_vld  = (m_rd >= 0);
        n_dout = m_dout;
        if (m_rd >= 0) n_dout = din[m_rd];
    endtask

    task automatic upd_empty();
        for (int i = 0; i < 4; i++) empty_r[i] = (fq[i].size() <= int'(pop[i]));
    endtask

    task automatic topup(input int n);
        for (int i = 0; i < 4; i++)
            while (fq[i].size() < n) fq[i].push_back(DW'($urandom));
        upd_empty();
    endtask

    task automatic check_outputs();
        chk("pop", pop, m_pop);
        chk("valid_out", valid_out, m_vld);
        chk("data_out", data_out, m_dout);
        chk("paused", paused, m_mask);
        chk("halted", halted, (m_st == M_HALT));
        if (valid_out) begin
            chk("sb_avail", (sb.size() > 0), 1);
            if (sb.size() > 0) chk("sb_data", data_out, sb.pop_front());
        end
    endtask

    // One clock: inputs already applied at posedge+1; strobes last one cycle.
    task automatic tick();
        logic [3:0] popcap;
        #1;
        model_next();
        popcap = pop;
        @(posedge CLK);
        #1;
        m_st = n_st; m_mask = n_mask; m_ptr = n_ptr; m_cnt = n_cnt;
        m_pop_prev = m_pop; m_pop = n_pop; m_rd = n_rd; m_vld = n_vld; m_dout = n_dout;
        for (int i = 0; i < 4; i++)
            if (popcap[i] && fq[i].size() > 0) begin
                din[i] = fq[i].pop_front();
                sb.push_back(din[i]);
            end
        pause_stb = 4'b0; continue_stb = 4'b0; error_full = 4'b0;
        upd_empty();
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_pop", pop, 4'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_data", data_out, 0);
        chk("rst_paused", paused, 4'b0);
        chk("rst_halted", halted, 1'b0);
        model_reset();
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        upd_empty();
    endtask

    initial begin
        int cnt_a, val_a, k, waited, pulses, exp_pulses;
        n_chk = 0; n_fail = 0;
        reset = 1'b0; pause_stb = 4'b0; continue_stb = 4'b0; idle = 1'b0;
        error_full = 4'b0; out_full = 1'b0; empty_r = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = '0;
        do_reset();

        // Single class with three words.
        idle = 1'b1; tick(); idle = 1'b0;
        for (int j = 0; j < 3; j++) fq[2].push_back(DW'($urandom));
        upd_empty();
        cnt_a = 0; val_a = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (pop == 4'b0100) cnt_a++;
            if (valid_out) val_a++;
        end
        chk("a_pops", cnt_a, 3);
        chk("a_valid", val_a, 3);

        // Full load from a fresh reset: grants rotate in quanta.
        do_reset();
        topup(6);
        idle = 1'b1; tick(); idle = 1'b0;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            tick(); topup(6);
            if (pop != 0 && k < 16) begin
                chk("grant_seq", $clog2(pop), (k / 4) % 4);
                k++;
            end
        end
        chk("grant_cnt", k, 16);

        // Pause class 0 mid-burst, then release it.
        waited = 0;
        while (m_pop != 4'b0001 && waited < 20) begin tick(); topup(6); waited++; end
        chk("wait_c0", (m_pop == 4'b0001), 1);
        pause_stb = 4'b0001; tick(); topup(6);
        for (int j = 0; j < 12; j++) begin tick(); topup(6); end
        continue_stb = 4'b0001; tick(); topup(6);
        for (int j = 0; j < 20; j++) begin tick(); topup(6); end
        pause_stb = 4'b1000; continue_stb = 4'b1000; tick();
        chk("pause_wins", paused[3], 1'b1);
        continue_stb = 4'b1000; tick(); topup(6);

        // Downstream stall.
        out_full = 1'b1;
        for (int j = 0; j < 5; j++) begin tick(); topup(6); chk("stall_pop", pop, 4'b0); end
        out_full = 1'b0;
        for (int j = 0; j < 12; j++) begin tick(); topup(6); end

        // Random traffic.
        begin
            int of_left;
            of_left = 0;
            for (int j = 0; j < 1500; j++) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom % 3 == 0 && fq[i].size() < 8) fq[i].push_back(DW'($urandom));
                upd_empty();
                pause_stb    = ($urandom % 12 == 0) ? 4'($urandom) : 4'b0;
                continue_stb = ($urandom % 5 == 0) ? 4'($urandom) : 4'b0;
                if (of_left == 0 && $urandom % 20 == 0) of_left = $urandom_range(1, 6);
                out_full = (of_left > 0);
                if (of_left > 0) of_left--;
                tick();
            end
            out_full = 1'b0;
        end

        // Overflow report with a word in flight.
        continue_stb = 4'hF; tick(); topup(6);
        waited = 0;
        while (m_pop == 4'b0 && waited < 20) begin tick(); topup(6); waited++; end
        chk("wait_inflight", (m_pop != 0), 1);
        exp_pulses = (m_pop_prev != 0) + 1;
        error_full = 4'b0010; tick();
        chk("halt_next", halted, 1'b1);
        chk("halt_pop", pop, 4'b0);
        pulses = valid_out ? 1 : 0;
        idle = 1'b1;
        for (int j = 0; j < 8; j++) begin
            pause_stb = 4'($urandom); topup(6); tick();
            if (valid_out) pulses++;
        end
        chk("halt_pulses", pulses, exp_pulses);
        chk("halt_sticky", halted, 1'b1);
        idle = 1'b0;

        // Reset leaves HALT; then reset mid-burst drops valid at once.
        do_reset();
        tick();
        chk("post_rst_halted", halted, 1'b0);
        topup(6);
        idle = 1'b1; tick(); idle = 1'b0;
        waited = 0;
        while (!m_vld && waited < 20) begin tick(); topup(6); waited++; end
        chk("wait_vld", m_vld, 1'b1);
        do_reset();
        for (int j = 0; j < 4; j++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
